// File: rtl/im_loader.sv
// im_loader: boot-time instruction-memory writer.
//
// Collects a byte stream (valid/ready) into little-endian 32-bit words and
// writes each finished word to consecutive instruction-memory addresses,
// starting at BASE_ADDR. The core is held in reset (o_cpu_hold) for the
// whole load so it never fetches a half-written program.
//
// Ports:
//   i_clk, i_reset      clock, synchronous active-high reset
//   i_start             begin a load (honoured only when idle or done)
//   i_word_count        words to load, captured with an accepted start
//   i_byte_valid/data   byte source, least-significant byte of a word first
//   o_byte_ready        loader takes a byte this cycle
//   o_we/o_wa/o_wd      instruction-memory write port (we is a 1-cycle pulse)
//   o_busy, o_cpu_hold  load in progress
//   o_done              level, from load completion until the next start
module im_loader #(
    parameter int ADDR_W    = 5,
    parameter int BASE_ADDR = 0
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [ADDR_W:0]   i_word_count,
    input  logic              i_byte_valid,
    input  logic [7:0]        i_byte_data,
    output logic              o_byte_ready,
    output logic              o_we,
    output logic [ADDR_W-1:0] o_wa,
    output logic [31:0]       o_wd,
    output logic              o_busy,
    output logic              o_cpu_hold,
    output logic              o_done
);

    localparam logic [ADDR_W-1:0] L_BASE = ADDR_W'(BASE_ADDR);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W:0]   r_remaining;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_byte_idx;
    logic [23:0]       r_buf;       // lanes 0..2; lane 3 goes straight into o_wd
    logic              r_we;
    logic              r_byte_ready;
    logic              r_busy;
    logic              r_done;
    logic [ADDR_W-1:0] r_wa;
    logic [31:0]       r_wd;

    logic w_start_ok;
    logic w_accept;
    logic w_we_n;
    logic w_ready_n;
    logic w_busy_n;
    logic w_done_n;

    assign w_start_ok = i_start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_accept   = (r_state == S_RECV) && i_byte_valid;

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_start_ok)
                    w_next = (i_word_count == '0) ? S_DONE : S_RECV;
            end
            S_RECV: begin
                if (w_accept && r_byte_idx == 2'd3) w_next = S_WRITE;
            end
            S_WRITE: begin
                // remaining is still the pre-decrement value here
                w_next = (r_remaining == (ADDR_W+1)'(1)) ? S_DONE : S_RECV;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Output logic: decoded from the next state so every output leaves a flop
    always_comb begin
        w_we_n    = (w_next == S_WRITE);
        w_ready_n = (w_next == S_RECV);
        w_busy_n  = (w_next == S_RECV) || (w_next == S_WRITE);
        w_done_n  = (w_next == S_DONE);
    end

    // Registered outputs and datapath
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_we         <= 1'b0;
            r_byte_ready <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_wa         <= '0;
            r_wd         <= '0;
            r_addr       <= '0;
            r_remaining  <= '0;
            r_byte_idx   <= 2'd0;
            r_buf        <= '0;
        end else begin
            r_we         <= w_we_n;
            r_byte_ready <= w_ready_n;
            r_busy       <= w_busy_n;
            r_done       <= w_done_n;

            if (w_start_ok) begin
                r_remaining <= i_word_count;
                r_addr      <= L_BASE;
                r_byte_idx  <= 2'd0;
            end

            if (w_accept) begin
                r_byte_idx <= r_byte_idx + 2'd1;
                case (r_byte_idx)
                    2'd0: r_buf[7:0]   <= i_byte_data;
                    2'd1: r_buf[15:8]  <= i_byte_data;
                    2'd2: r_buf[23:16] <= i_byte_data;
                    default: begin
                        // Last lane: present the word on the write port now
                        r_wd <= {i_byte_data, r_buf};
                        r_wa <= r_addr;
                    end
                endcase
            end

            if (r_state == S_WRITE) begin
                r_addr      <= r_addr + 1'b1;   // wraps modulo 2^ADDR_W
                r_remaining <= r_remaining - 1'b1;
                r_byte_idx  <= 2'd0;
            end
        end
    end

    assign o_we         = r_we;
    assign o_byte_ready = r_byte_ready;
    assign o_busy       = r_busy;
    assign o_cpu_hold   = r_busy;
    assign o_done       = r_done;
    assign o_wa         = r_wa;
    assign o_wd         = r_wd;

endmodule

// File: doc/im_loader.md
# im_loader

Boot-time writer for the instruction memory. It receives the program as a stream of bytes over a valid/ready handshake and assembles each group of four bytes into a little-endian 32-bit word. Each finished word is written to consecutive instruction-memory addresses through a single write port. While loading, it holds the processor in reset via `cpu_hold` so that no fetch reads a partially written program.

## Interface
- `ADDR_W`, 5, instruction-memory address width (32 words)
- `BASE_ADDR`, 0, first word address written by every load
- `clk`  in  1  single clock, all logic rising-edge
- `reset`  in  1  synchronous, active-high
- `start`  in  1  begin a load; sampled only in IDLE and DONE
- `word_count`  in  ADDR_W+1  number of words to load; sampled on the accepted `start`
- `byte_valid`  in  1  source has a byte on `byte_data`
- `byte_data`  in  8  program byte, least-significant byte of each word first
- `byte_ready`  out  1  loader accepts a byte this cycle
- `we`  out  1  instruction-memory write enable, one-cycle pulse per word
- `wa`  out  ADDR_W  write address
- `wd`  out  32  write data
- `busy`  out  1  load in progress (RECV or WRITE)
- `cpu_hold`  out  1  equals `busy`; keeps the core in reset
- `done`  out  1  level; high from load completion until the next accepted `start`

## Operation
- States:
  - IDLE
  - RECV: collecting bytes
  - WRITE: one-cycle memory write
  - DONE
- IDLE:
  - `byte_ready`=0.
  - `start`=1 latches `remaining`=`word_count`, `addr`=`BASE_ADDR`, `byte_idx`=0.
  - Then goes to DONE if `word_count`==0, otherwise to RECV.
- RECV:
  - `byte_ready`=1.
  - A byte is accepted when `byte_valid`&&`byte_ready`.
  - The accepted byte is stored in lane `byte_idx` (lane 0 = bits 7:0, lane 3 = bits 31:24), and `byte_idx` increments.
  - Acceptance of lane 3 moves to WRITE.
- WRITE:
  - `we`=1, `wa`=`addr`, `wd`=assembled word, `byte_ready`=0.
  - On exit: `addr`←`addr`+1 modulo 2^ADDR_W (wraps 31→0), `remaining`←`remaining`−1, `byte_idx`←0.
  - Goes to DONE if the new `remaining`==0, otherwise back to RECV.
- DONE:
  - `done`=1, `busy`=0.
  - `start`=1 re-runs the IDLE acceptance rule in the same cycle, so DONE can go directly to RECV.
- `start` is ignored in RECV and WRITE.
- `byte_valid` is ignored outside RECV, and no byte is consumed.
- Word counts larger than 2^ADDR_W are legal; the address wraps and earlier words are overwritten.
- `wa` and `wd` hold their last values when `we`=0.

## Timing
- Reset, cycle after `reset`=1:
  - state IDLE.
  - `we`, `byte_ready`, `busy`, `cpu_hold`, `done` = 0.
  - `wa`, `wd`, `addr` = 0; `byte_idx` = 0.
- `reset` overrides everything, including mid-load. A partial word is discarded, with no `we`.
- Accepted `start` in cycle N:
  - `busy` and `byte_ready` are high in N+1.
  - If `word_count`==0, `done` is high in N+1 and `busy` never rises.
- Last byte of a word accepted in cycle N: `we` is high in cycle N+1, exactly one cycle.
- After the final word's write in cycle M: `done`=1 and `busy`=0 in cycle M+1.
- With `byte_valid` held high, peak throughput is 4 bytes per 5 cycles.
- Source stalls (`byte_valid` low) may occur at any lane. The lane position is kept and no data is lost.
- All outputs are registered.

## Test plan
- Single word:
  - Stimulus: `start` with `word_count`=1, then bytes 67,45,23,01 back-to-back.
  - Response: one `we` pulse, `wa`=0, `wd`=32'h01234567, one cycle after the 4th byte; `done`=1 the following cycle.
- Three words:
  - Stimulus: `word_count`=3, bytes encoding 32'h01234567, 32'h01234333, 32'h01234569.
  - Response: writes at `wa` 0, 1, 2 with those values; `cpu_hold` high throughout; exactly 3 `we` pulses.
- Source stalls:
  - Stimulus: same single word with `byte_valid` low for 3 cycles between each byte.
  - Response: identical `wd`=32'h01234567, and no byte is accepted while `byte_valid`=0.
- Zero count:
  - Stimulus: `start` with `word_count`=0.
  - Response: `done`=1 in the next cycle, `we` never asserted, `byte_ready` never asserted.
- Address wrap:
  - Stimulus: `BASE_ADDR`=30, `word_count`=3.
  - Response: writes at `wa` 30, 31, 0.
- Reset mid-load:
  - Stimulus: assert `reset` after 2 bytes are accepted.
  - Response: no `we`, all outputs at reset values. A fresh load then writes 32'h01234567 to address 0, starting at lane 0.
